// File: rtl/seq_detect_prog_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package seq_det_pkg;

  // Detector FSM: no configuration, collecting bits, or history full.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Default sizing of the detector and the saturation value of its default counter.
  localparam int unsigned MAX_LEN_DEFAULT = 32'd8;
  localparam int unsigned CNT_W_DEFAULT   = 32'd8;
  localparam int unsigned CNT_SAT_DEFAULT = (32'd1 << CNT_W_DEFAULT) - 32'd1;

  // A pattern length is usable when it is 1..max_len.
  function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
    return (len >= 32'd1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Configuration, serial-stream and result signals of the pattern detector.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               in_valid;
  logic               in_bit;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               count_clr;

  // Side that drives configuration and data (front-end / control logic).
  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output in_valid, in_bit, count_clr,
    input  cfg_err, match, match_count
  );

  // Side implemented by the detector.
  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  in_valid, in_bit, count_clr,
    output cfg_err, match, match_count
  );
endinterface

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] SAT = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, otherwise increment until all ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (inc && (count_q != SAT)) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable Mealy serial-pattern detector with overlap control and a
// saturating match counter. Bit 0 of the pattern is the most recent bit.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_prog_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               match_q, match_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] hist_shift_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               accept_s;
  logic               cmp_eq_s;
  logic               hit_s;

  // History after shifting in the current bit; fill count saturating at len.
  assign hist_shift_s = {hist_q[MAX_LEN-2:0], bus.in_bit};
  assign fill_inc_s   = (fill_q == len_q) ? fill_q : (fill_q + LEN_W'(1));

  // Mask selecting the low len bits of history/pattern for comparison.
  always_comb begin
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end
  end

  // A bit counts only when configured and no load competes for the cycle.
  assign accept_s = bus.in_valid && !bus.cfg_load &&
                    ((state_q == ST_FILL) || (state_q == ST_RUN));
  assign cmp_eq_s = (((hist_shift_s ^ pat_q) & mask_s) == {MAX_LEN{1'b0}});
  assign hit_s    = accept_s && (fill_inc_s == len_q) && cmp_eq_s;

  // Next state for configuration, history, fill count and FSM.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    if (bus.cfg_load) begin
      hist_d = {MAX_LEN{1'b0}};
      fill_d = {LEN_W{1'b0}};
      if (len_ok(32'(bus.cfg_len), 32'(MAX_LEN))) begin
        pat_d   = bus.cfg_pattern;
        len_d   = bus.cfg_len;
        ovl_d   = bus.cfg_overlap;
        state_d = ST_FILL;
      end else begin
        // Rejected load drops the old configuration entirely.
        pat_d     = {MAX_LEN{1'b0}};
        len_d     = {LEN_W{1'b0}};
        ovl_d     = 1'b0;
        state_d   = ST_IDLE;
        cfg_err_d = 1'b1;
      end
    end else if (bus.in_valid) begin
      case (state_q)
        ST_FILL, ST_RUN: begin
          hist_d = hist_shift_s;
          fill_d = fill_inc_s;
          if (hit_s) begin
            match_d = 1'b1;
            if (ovl_q) begin
              state_d = ST_RUN;
            end else begin
              // Non-overlapping: the next match needs a fresh len bits.
              fill_d  = {LEN_W{1'b0}};
              state_d = ST_FILL;
            end
          end else if (fill_inc_s == len_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FILL;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Detector registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hist_q    <= {MAX_LEN{1'b0}};
      fill_q    <= {LEN_W{1'b0}};
      pat_q     <= {MAX_LEN{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      ovl_q     <= 1'b0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  logic [CNT_W-1:0] count_s;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_s),
    .clr   (bus.count_clr),
    .count (count_s)
  );

  assign bus.match       = match_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.match_count = count_s;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: two instances (8-bit and 2-bit
// counters) share one stimulus; a bit-queue model predicts each cycle.
module tb_seq_detect_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(8)) if_a ();
  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) if_b ();

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct {
    logic match;
    logic err;
    int   cnt_a;
    int   cnt_b;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  bit         m_valid = 1'b0;
  logic [7:0] m_pat   = 8'h00;
  int         m_len   = 0;
  bit         m_ovl   = 1'b0;
  bit         m_acc[$];
  int         m_cnt_a = 0;
  int         m_cnt_b = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input bit load, input logic [7:0] pat, input int len, input bit ovl,
                       input bit vld, input bit b, input bit clr);
    if_a.cfg_load = load; if_a.cfg_pattern = pat; if_a.cfg_len = 4'(len);
    if_a.cfg_overlap = ovl; if_a.in_valid = vld; if_a.in_bit = b; if_a.count_clr = clr;
    if_b.cfg_load = load; if_b.cfg_pattern = pat; if_b.cfg_len = 4'(len);
    if_b.cfg_overlap = ovl; if_b.in_valid = vld; if_b.in_bit = b; if_b.count_clr = clr;
  endtask

  // One clock: drive, predict, push; after the edge pop and compare.
  task automatic cycle(input bit load, input logic [7:0] pat, input int len, input bit ovl,
                       input bit vld, input bit b, input bit clr);
    exp_t e;
    exp_t got;
    bit   hit;
    drive(load, pat, len, ovl, vld, b, clr);
    hit   = 1'b0;
    e.err = 1'b0;
    if (load) begin
      m_acc.delete();
      if (len >= 1 && len <= 8) begin
        m_valid = 1'b1; m_pat = pat; m_len = len; m_ovl = ovl;
      end else begin
        m_valid = 1'b0;
        e.err   = 1'b1;
      end
    end else if (vld && m_valid) begin
      m_acc.push_back(b);
      if (m_acc.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++) begin
          if (m_acc[m_acc.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        end
      end
      if (hit && !m_ovl) m_acc.delete();
      if (m_acc.size() > 8) void'(m_acc.pop_front());
    end
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    e.match = hit;
    e.cnt_a = m_cnt_a;
    e.cnt_b = m_cnt_b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check_val("match_a", 32'(if_a.match), 32'(got.match));
      check_val("err_a", 32'(if_a.cfg_err), 32'(got.err));
      check_val("count_a", 32'(if_a.match_count), 32'(got.cnt_a));
      check_val("match_b", 32'(if_b.match), 32'(got.match));
      check_val("err_b", 32'(if_b.cfg_err), 32'(got.err));
      check_val("count_b", 32'(if_b.match_count), 32'(got.cnt_b));
    end
  endtask

  task automatic send(input bit b);
    cycle(1'b0, 8'h00, 0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input int l, input bit o);
    cycle(1'b1, p, l, o, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_cnt();
    cycle(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Sends n bits of s, MSB first (first received bit first).
  task automatic send_vec(input logic [15:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) send(s[i]);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    drive(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check_val("rst_match_a", 32'(if_a.match), 32'd0);
    check_val("rst_err_a", 32'(if_a.cfg_err), 32'd0);
    check_val("rst_count_a", 32'(if_a.match_count), 32'd0);
    check_val("rst_count_b", 32'(if_b.match_count), 32'd0);
    m_valid = 1'b0; m_pat = 8'h00; m_len = 0; m_ovl = 1'b0;
    m_acc.delete(); m_cnt_a = 0; m_cnt_b = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s1001;
    s1001 = 16'b1001001;
    drive(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Unconfigured: bits ignored.
    send(1'b1); send(1'b1); send(1'b0);

    // Overlapping 1001 on 1001001: matches after bits 4 and 7.
    load(8'h09, 4, 1'b1);
    send_vec(s1001, 7);
    check_val("ovl_total", 32'(if_a.match_count), 32'd2);
    idle();

    // Non-overlapping, pattern upper bits set to show they are masked out.
    clear_cnt();
    load(8'hF9, 4, 1'b0);
    send_vec(s1001, 7);
    check_val("novl_total", 32'(if_a.match_count), 32'd1);

    // Illegal lengths: error pulse, detector stays idle.
    load(8'hFF, 0, 1'b1);
    for (int i = 0; i < 10; i++) send(1'b1);
    load(8'h01, 9, 1'b1);
    for (int i = 0; i < 10; i++) send(1'b1);
    check_val("idle_total", 32'(if_a.match_count), 32'd1);

    // Single-bit pattern, back-to-back matches, 2-bit counter saturation.
    clear_cnt();
    load(8'h01, 1, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b1);
    check_val("sat_b", 32'(if_b.match_count), 32'd3);
    check_val("nosat_a", 32'(if_a.match_count), 32'd6);
    cycle(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_val("clr_vs_match_m", 32'(if_a.match), 32'd1);
    check_val("clr_vs_match_c", 32'(if_b.match_count), 32'd0);

    // 1001 overlapped with in_valid gaps of 0..3 cycles.
    clear_cnt();
    load(8'h09, 4, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      for (int g = 0; g < (i % 4); g++) idle();
      send(s1001[i]);
    end
    check_val("gap_total", 32'(if_a.match_count), 32'd2);

    // Reset mid-pattern, then the final bit must not match.
    load(8'h09, 4, 1'b1);
    send(1'b1); send(1'b0); send(1'b0);
    do_reset();
    send(1'b1);
    send_vec(16'b1001, 4);
    check_val("post_rst_total", 32'(if_a.match_count), 32'd0);
    load(8'h09, 4, 1'b1);
    send_vec(16'b1001, 4);
    check_val("reload_total", 32'(if_a.match_count), 32'd1);

    // Load together with a valid bit: that bit is discarded.
    cycle(1'b1, 8'h09, 4, 1'b0, 1'b1, 1'b1, 1'b0);
    send_vec(16'b001001, 6);
    check_val("load_vs_bit", 32'(if_a.match_count), 32'd2);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
